// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC decimator sequencing: integrator gate, comb strobe, warm-up discard, output register
module cic_dec_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_RATE = 64,
    parameter int N_STAGES = 3,
    parameter int RATE_W   = $clog2(MAX_RATE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              cfg_load,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  comb_out,
    output logic              int_en,
    output logic              dec_stb,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              rate_err,
    output logic              busy
);

    // Warm-up counter only needs to count strobes 0..N_STAGES-1.
    localparam int WARM_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [RATE_W-1:0] RATE_RST  = RATE_W'(4);
    localparam logic [RATE_W-1:0] RATE_MIN  = RATE_W'(2);
    localparam logic [RATE_W-1:0] RATE_MAX  = RATE_W'(MAX_RATE);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t            state;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic              cap_pend;

    logic [RATE_W-1:0] rate_last;
    logic              phase_wrap;
    logic              rate_ok;

    // Phase decode and strobe generation; strobe stands in for the slow decimated clock.
    always_comb begin
        rate_last  = rate - RATE_W'(1);
        phase_wrap = (cnt == rate_last);
        rate_ok    = (cfg_rate >= RATE_MIN) && (cfg_rate <= RATE_MAX);
        busy       = (state != S_IDLE);
        int_en     = in_valid & busy;
        dec_stb    = int_en & phase_wrap;
    end

    // Control FSM: rate configuration, phase/warm-up counting and capture request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rate     <= RATE_RST;
            cnt      <= '0;
            warm_cnt <= '0;
            cap_pend <= 1'b0;
            rate_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cap_pend <= 1'b0;
                    // Rate may only change while the filter is stopped.
                    if (cfg_load) begin
                        if (rate_ok) begin
                            rate     <= cfg_rate;
                            rate_err <= 1'b0;
                        end else begin
                            rate_err <= 1'b1;
                        end
                    end
                    if (enable) begin
                        state    <= S_WARMUP;
                        cnt      <= '0;
                        warm_cnt <= '0;
                    end
                end

                S_WARMUP: begin
                    cap_pend <= 1'b0;
                    if (!enable) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        warm_cnt <= '0;
                    end else begin
                        if (int_en) begin
                            cnt <= phase_wrap ? '0 : cnt + RATE_W'(1);
                        end
                        // Comb outputs are garbage until every stage has seen a full window.
                        if (dec_stb) begin
                            if (warm_cnt == WARM_LAST) begin
                                state    <= S_RUN;
                                warm_cnt <= '0;
                            end else begin
                                warm_cnt <= warm_cnt + WARM_W'(1);
                            end
                        end
                    end
                end

                S_RUN: begin
                    if (!enable) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        warm_cnt <= '0;
                        cap_pend <= 1'b0;
                    end else begin
                        if (int_en) begin
                            cnt <= phase_wrap ? '0 : cnt + RATE_W'(1);
                        end
                        // Comb result appears one cycle after the strobe.
                        cap_pend <= dec_stb;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    warm_cnt <= '0;
                    cap_pend <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (cap_pend) begin
                // Load when empty or being drained this cycle; otherwise keep the old sample.
                if (!out_valid || out_ready) begin
                    out_data  <= comb_out;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - scoreboard bench for cic_dec_ctrl
module tb_cic_dec_ctrl;

    localparam int WIDTH    = 16;
    localparam int MAX_RATE = 64;
    localparam int N_STAGES = 3;
    localparam int RATE_W   = $clog2(MAX_RATE) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [RATE_W-1:0] cfg_rate = '0;
    logic              cfg_load = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  comb_out = '0;
    logic              out_ready = 1'b0;
    logic              int_en;
    logic              dec_stb;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              overrun;
    logic              rate_err;
    logic              busy;

    cic_dec_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_RATE (MAX_RATE),
        .N_STAGES (N_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_rate  (cfg_rate),
        .cfg_load  (cfg_load),
        .enable    (enable),
        .in_valid  (in_valid),
        .comb_out  (comb_out),
        .int_en    (int_en),
        .dec_stb   (dec_stb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .rate_err  (rate_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    // Reference model: counts of accepted inputs and strobes since enable.
    int m_rate;
    bit m_busy;
    int m_acc;
    int m_strobes;
    bit m_cap;
    bit m_valid;
    bit m_overrun;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_strobe();
        return m_busy && in_valid && (((m_acc + 1) % m_rate) == 0);
    endfunction

    task automatic model_reset();
        m_rate    = 4;
        m_busy    = 0;
        m_acc     = 0;
        m_strobes = 0;
        m_cap     = 0;
        m_valid   = 0;
        m_overrun = 0;
        m_err     = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_update();
        bit stb;
        stb = m_strobe();
        if (m_cap) begin
            if (!m_valid || out_ready) begin
                exp_q.push_back(comb_out);
                m_valid = 1;
            end else begin
                m_overrun = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        m_cap = m_busy && enable && stb && (m_strobes >= N_STAGES);
        if (m_busy) begin
            if (!enable) begin
                m_busy = 0;
            end else begin
                if (in_valid) m_acc++;
                if (stb) m_strobes++;
            end
        end else begin
            if (cfg_load) begin
                if (cfg_rate >= 2 && cfg_rate <= MAX_RATE) begin
                    m_rate = int'(cfg_rate);
                    m_err  = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (enable) begin
                m_busy    = 1;
                m_acc     = 0;
                m_strobes = 0;
            end
        end
    endtask

    task automatic step();
        comb_out = WIDTH'($urandom);
        @(negedge clk);
        check("int_en",    int_en,    m_busy && in_valid);
        check("dec_stb",   dec_stb,   m_strobe());
        check("busy",      busy,      m_busy);
        check("out_valid", out_valid, m_valid);
        check("overrun",   overrun,   m_overrun);
        check("rate_err",  rate_err,  m_err);
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic pick(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run(input int n, input int ivm, input int rdm);
        for (int i = 0; i < n; i++) begin
            in_valid  = pick(ivm, i);
            out_ready = pick(rdm, i);
            step();
        end
    endtask

    task automatic load(input int v);
        cfg_rate = RATE_W'(v);
        cfg_load = 1'b1;
        in_valid = 1'b0;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic stop();
        enable   = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_overrun",   overrun,   1'b0);
        check("rst_rate_err",  rate_err,  1'b0);
        check("rst_int_en",    int_en,    1'b0);
        model_reset();
        enable   = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every consumed sample must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data: got %0h expected none (queue empty) at %0t", out_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", out_data, mon_exp);
            end
        end
    end

    initial begin
        model_reset();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_data",  out_data,  '0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy",      busy,      1'b0);
        check("reset_int_en",    int_en,    1'b0);
        check("reset_dec_stb",   dec_stb,   1'b0);
        check("reset_overrun",   overrun,   1'b0);
        check("reset_rate_err",  rate_err,  1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Rate 4, continuous input, warm-up discard.
        out_ready = 1'b1;
        load(4);
        enable = 1'b1;
        run(40, 1, 1);

        // Rate 8 with toggling input.
        stop();
        load(8);
        enable = 1'b1;
        run(120, 2, 3);

        // Out-of-range loads, then rate 2, then load while busy.
        stop();
        load(1);
        load(MAX_RATE + 1);
        load(2);
        enable = 1'b1;
        run(10, 1, 1);
        cfg_rate = RATE_W'(5);
        cfg_load = 1'b1;
        run(3, 1, 1);
        cfg_load = 1'b0;
        run(20, 3, 1);

        // Back-pressure: held sample and overrun, then drain.
        run(20, 1, 0);
        run(6, 1, 1);

        // Clean back-to-back capture/consume at rate 2.
        reset_pulse();
        load(2);
        enable = 1'b1;
        run(40, 1, 1);

        // Warm-up restart and reset mid-RUN.
        stop();
        load(4);
        enable = 1'b1;
        run(6, 1, 1);
        stop();
        enable = 1'b1;
        run(30, 1, 3);
        run(30, 1, 0);
        reset_pulse();
        enable = 1'b1;
        run(30, 1, 1);

        // Randomized rates and traffic.
        for (int k = 0; k < 6; k++) begin
            stop();
            load(int'($urandom_range(1, 12)));
            enable = 1'b1;
            run(int'($urandom_range(30, 80)), 3, 3);
        end

        enable = 1'b0;
        run(6, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
